ip_fifo_unpacker: RTL and testbench

Read-side companion to the team's parameterised FIFO. It drains wide words from the FIFO read port (avail / read-enable / read-data, synchronous or asynchronous read) and serialises each word into narrower chunks on a valid/ready output stream. Typical use is feeding 8-bit transmit engines (UART/SPI TX paths) from 32-bit CPU-side FIFOs.

---
 rtl/ip_fifo_unpacker_if.sv | 37 +++
 rtl/ip_fifo_unpacker.sv | 93 +++++++++
 tb/tb_ip_fifo_unpacker.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_fifo_unpacker_if.sv
// Signal bundle between the unpacker, the read port of its source FIFO and
// the downstream narrow-chunk stream.
interface ip_fifo_unpacker_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
);
    logic                 i_fifo_avail;
    logic                 o_fifo_re;
    logic [IN_WIDTH-1:0]  i_fifo_rdata;
    logic                 o_valid;
    logic [OUT_WIDTH-1:0] o_data;
    logic                 o_last;
    logic                 i_ready;
    logic                 o_busy;

    modport master (
        input  i_fifo_avail,
        input  i_fifo_rdata,
        input  i_ready,
        output o_fifo_re,
        output o_valid,
        output o_data,
        output o_last,
        output o_busy
    );

    modport slave (
        output i_fifo_avail,
        output i_fifo_rdata,
        output i_ready,
        input  o_fifo_re,
        input  o_valid,
        input  o_data,
        input  o_last,
        input  o_busy
    );
endinterface

// File: rtl/ip_fifo_unpacker.sv
// Drains wide FIFO words one at a time and serialises each into OUT_WIDTH
// chunks on a valid/ready stream; no prefetch, at most one word held.
module ip_fifo_unpacker #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int FIFO_RSYNC = 1,
    parameter int LSB_FIRST  = 1
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_clear,
    ip_fifo_unpacker_if.master bus
);
    localparam int N     = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if ((IN_WIDTH % OUT_WIDTH) != 0 || N < 1) begin : g_bad_width
        $error("ip_fifo_unpacker: IN_WIDTH must be a multiple of OUT_WIDTH");
    end
    if (FIFO_RSYNC != 0 && FIFO_RSYNC != 1) begin : g_bad_rsync
        $error("ip_fifo_unpacker: FIFO_RSYNC must be 0 or 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t               state;
    logic [IN_WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]     count;
    logic                 last_q;
    logic                 pop;

    // Move the next chunk into the output end of the shift register.
    function automatic logic [IN_WIDTH-1:0] advance(input logic [IN_WIDTH-1:0] w);
        if (LSB_FIRST != 0) return w >> OUT_WIDTH;
        else                return w << OUT_WIDTH;
    endfunction

    function automatic logic [OUT_WIDTH-1:0] head(input logic [IN_WIDTH-1:0] w);
        if (LSB_FIRST != 0) return w[OUT_WIDTH-1:0];
        else                return w[IN_WIDTH-1 -: OUT_WIDTH];
    endfunction

    // Pops only from IDLE, so consecutive pops are N+1 cycles apart; that
    // covers the one-cycle avail/rdata lag of a sync-read FIFO in both modes.
    assign pop = i_rstn & (state == IDLE) & bus.i_fifo_avail & ~i_clear;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state  <= IDLE;
            shreg  <= '0;
            count  <= '0;
            last_q <= 1'b0;
        end else if (i_clear) begin
            state  <= IDLE;
            count  <= '0;
            last_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        state  <= EMIT;
                        shreg  <= bus.i_fifo_rdata;
                        count  <= '0;
                        last_q <= (N == 1);
                    end
                end
                EMIT: begin
                    if (bus.i_ready) begin
                        if (last_q) begin
                            state  <= IDLE;
                            last_q <= 1'b0;
                        end else begin
                            shreg  <= advance(shreg);
                            count  <= count + CNT_W'(1);
                            last_q <= (count == CNT_W'(N - 2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_fifo_re = pop;
    assign bus.o_valid   = (state == EMIT);
    assign bus.o_busy    = (state == EMIT);
    assign bus.o_data    = head(shreg);
    assign bus.o_last    = last_q;

endmodule

// File: tb/tb_ip_fifo_unpacker.sv
// Bench for ip_fifo_unpacker: three instances (32->8 LSB-first sync FIFO,
// 32->8 MSB-first async FIFO, 8->8 sync FIFO) against a chunk-index model.
module tb_ip_fifo_unpacker;
    localparam int ND = 3;
    localparam int NN   [ND] = '{4, 4, 1};
    localparam int LSBF [ND] = '{1, 0, 1};
    localparam int SYNC [ND] = '{1, 0, 1};

    localparam logic [7:0] EXP1_LSB [8]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    localparam logic [7:0] EXP1_MSB [8]  = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55};
    localparam logic [7:0] EXP3_LSB [12] = '{8'hA3, 8'hA2, 8'hA1, 8'hA0, 8'hB3, 8'hB2,
                                             8'hB1, 8'hB0, 8'hC3, 8'hC2, 8'hC1, 8'hC0};
    localparam logic [7:0] EXP3_MSB [12] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1,
                                             8'hB2, 8'hB3, 8'hC0, 8'hC1, 8'hC2, 8'hC3};

    logic clk = 1'b0;
    logic rstn;
    logic clr  [ND];
    logic rdy  [ND];
    logic avail[ND];
    logic [31:0] rdata [ND];
    logic v [ND], re [ND], lst [ND], bsy [ND];
    logic [7:0] dat [ND];

    logic [31:0] mem [ND][16];
    int          wp [ND];
    int          rp [ND];
    logic        avail_s [ND] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] rdata_s [ND];

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;

    bit          m_busy [ND];
    bit          m_rst  [ND] = '{1'b1, 1'b1, 1'b1};
    logic [31:0] m_word [ND];
    int          m_idx  [ND];

    logic [7:0] lg_d [ND][64];
    logic       lg_l [ND][64];
    int         lg_c [ND][64];
    int         nlog [ND];
    int         pop_c[ND][64];
    int         npop [ND];

    logic       e_v, e_l, e_re;
    logic [7:0] e_d;
    int         sel;

    always #5 clk = ~clk;

    ip_fifo_unpacker_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) bus0 ();
    ip_fifo_unpacker_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) bus1 ();
    ip_fifo_unpacker_if #(.IN_WIDTH(8),  .OUT_WIDTH(8)) bus2 ();

    ip_fifo_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .FIFO_RSYNC(1), .LSB_FIRST(1)) dut0 (
        .i_clk(clk), .i_rstn(rstn), .i_clear(clr[0]), .bus(bus0.master));
    ip_fifo_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8), .FIFO_RSYNC(0), .LSB_FIRST(0)) dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_clear(clr[1]), .bus(bus1.master));
    ip_fifo_unpacker #(.IN_WIDTH(8), .OUT_WIDTH(8), .FIFO_RSYNC(1), .LSB_FIRST(1)) dut2 (
        .i_clk(clk), .i_rstn(rstn), .i_clear(clr[2]), .bus(bus2.master));

    assign bus0.i_fifo_avail = avail[0];
    assign bus0.i_fifo_rdata = rdata[0];
    assign bus0.i_ready      = rdy[0];
    assign bus1.i_fifo_avail = avail[1];
    assign bus1.i_fifo_rdata = rdata[1];
    assign bus1.i_ready      = rdy[1];
    assign bus2.i_fifo_avail = avail[2];
    assign bus2.i_fifo_rdata = rdata[2][7:0];
    assign bus2.i_ready      = rdy[2];

    assign v[0] = bus0.o_valid;  assign re[0] = bus0.o_fifo_re;  assign lst[0] = bus0.o_last;
    assign bsy[0] = bus0.o_busy; assign dat[0] = bus0.o_data;
    assign v[1] = bus1.o_valid;  assign re[1] = bus1.o_fifo_re;  assign lst[1] = bus1.o_last;
    assign bsy[1] = bus1.o_busy; assign dat[1] = bus1.o_data;
    assign v[2] = bus2.o_valid;  assign re[2] = bus2.o_fifo_re;  assign lst[2] = bus2.o_last;
    assign bsy[2] = bus2.o_busy; assign dat[2] = bus2.o_data;

    // Source FIFOs: sync-read ones present avail/rdata one cycle late.
    always_comb begin
        for (int k = 0; k < ND; k++) begin
            avail[k] = (SYNC[k] != 0) ? avail_s[k] : (wp[k] != rp[k]);
            rdata[k] = (SYNC[k] != 0) ? rdata_s[k] : mem[k][rp[k] % 16];
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < ND; k++) begin
            avail_s[k] <= (wp[k] != rp[k]);
            rdata_s[k] <= mem[k][rp[k] % 16];
            if (re[k] === 1'b1) rp[k] <= rp[k] + 1;
        end
    end

    // Model: a held word plus the index of the chunk on the output.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < ND; k++) begin
                m_busy[k] = 1'b0;
                m_rst[k]  = 1'b1;
            end
        end else begin
            cyc = cyc + 1;
            for (int k = 0; k < ND; k++) begin
                if (v[k] === 1'b1 && rdy[k] && !clr[k] && nlog[k] < 64) begin
                    lg_d[k][nlog[k]] = dat[k];
                    lg_l[k][nlog[k]] = lst[k];
                    lg_c[k][nlog[k]] = cyc;
                    nlog[k] = nlog[k] + 1;
                end
                if (re[k] === 1'b1 && npop[k] < 64) begin
                    pop_c[k][npop[k]] = cyc;
                    npop[k] = npop[k] + 1;
                end
                if (clr[k]) begin
                    m_busy[k] = 1'b0;
                end else if (!m_busy[k]) begin
                    if (avail[k] === 1'b1) begin
                        m_busy[k] = 1'b1;
                        m_word[k] = rdata[k];
                        m_idx[k]  = 0;
                        m_rst[k]  = 1'b0;
                    end
                end else if (rdy[k]) begin
                    if (m_idx[k] == NN[k] - 1) m_busy[k] = 1'b0;
                    else                       m_idx[k] = m_idx[k] + 1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec = nvec + 1;
        if (act !== exp) begin
            nfail = nfail + 1;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < ND; k++) begin
            e_v  = m_busy[k];
            e_l  = m_busy[k] && (m_idx[k] == NN[k] - 1);
            e_re = !m_busy[k] && (avail[k] === 1'b1) && !clr[k] && (rstn === 1'b1);
            sel  = (LSBF[k] != 0) ? m_idx[k] : (NN[k] - 1 - m_idx[k]);
            e_d  = 8'((m_word[k] >> (8 * sel)) & 32'hFF);
            chk($sformatf("valid[%0d]", k), 32'(v[k]),   32'(e_v));
            chk($sformatf("busy[%0d]", k),  32'(bsy[k]), 32'(e_v));
            chk($sformatf("last[%0d]", k),  32'(lst[k]), 32'(e_l));
            chk($sformatf("re[%0d]", k),    32'(re[k]),  32'(e_re));
            if (m_busy[k])     chk($sformatf("data[%0d]", k), 32'(dat[k]), 32'(e_d));
            else if (m_rst[k]) chk($sformatf("rstdata[%0d]", k), 32'(dat[k]), 32'd0);
        end
    end

    task automatic push(input int k, input logic [31:0] w);
        mem[k][wp[k] % 16] = w;
        wp[k] = wp[k] + 1;
    endtask

    task automatic wait_valid(input int k, input int budget, input string nm);
        int t;
        t = 0;
        while (v[k] !== 1'b1 && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(nm, 32'(v[k]), 32'd1);
    endtask

    initial begin
        int b0, b1, b2, p0, p1, p2, np;
        rstn = 1'b0;
        for (int k = 0; k < ND; k++) begin
            clr[k] = 1'b0;
            rdy[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // Two words back to back, ready held high.
        for (int k = 0; k < ND; k++) rdy[k] = 1'b1;
        b0 = nlog[0]; b1 = nlog[1]; p0 = npop[0]; p1 = npop[1];
        push(0, 32'h44332211); push(0, 32'h88776655);
        push(1, 32'h44332211); push(1, 32'h88776655);
        repeat (16) @(posedge clk);
        #1;
        chk("p1_chunks0", 32'(nlog[0] - b0), 32'd8);
        chk("p1_chunks1", 32'(nlog[1] - b1), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("p1_lsb%0d", i),  32'(lg_d[0][b0 + i]), 32'(EXP1_LSB[i]));
            chk($sformatf("p1_msb%0d", i),  32'(lg_d[1][b1 + i]), 32'(EXP1_MSB[i]));
            chk($sformatf("p1_last%0d", i), 32'(lg_l[0][b0 + i]), (i % 4 == 3) ? 32'd1 : 32'd0);
        end
        chk("p1_pops0",    32'(npop[0] - p0), 32'd2);
        chk("p1_pops1",    32'(npop[1] - p1), 32'd2);
        chk("p1_latency0", 32'(lg_c[0][b0] - pop_c[0][p0]), 32'd1);
        chk("p1_latency1", 32'(lg_c[1][b1] - pop_c[1][p1]), 32'd1);
        chk("p1_consec",   32'(lg_c[0][b0 + 3] - lg_c[0][b0]), 32'd3);
        chk("p1_nextpop",  32'(pop_c[0][p0 + 1] - lg_c[0][b0 + 3]), 32'd1);

        // Back-pressure on the first chunk.
        rdy[0] = 1'b0;
        b0 = nlog[0];
        push(0, 32'h44332211);
        wait_valid(0, 20, "bp_wait");
        np = npop[0];
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i),  32'(dat[0]), 32'h11);
            chk($sformatf("bp_valid%0d", i), 32'(v[0]),   32'd1);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rdy[0] = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("bp_nopop", 32'(npop[0] - np), 32'd0);
        chk("bp_count", 32'(nlog[0] - b0), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("bp_seq%0d", i), 32'(lg_d[0][b0 + i]), 32'(EXP1_LSB[i]));

        // Three queued words with a ready pattern, sync and async FIFOs.
        b0 = nlog[0]; b1 = nlog[1]; p0 = npop[0]; p1 = npop[1];
        push(0, 32'hA0A1A2A3); push(0, 32'hB0B1B2B3); push(0, 32'hC0C1C2C3);
        push(1, 32'hA0A1A2A3); push(1, 32'hB0B1B2B3); push(1, 32'hC0C1C2C3);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            rdy[0] = (i % 3 != 1);
            rdy[1] = (i % 4 != 2);
        end
        rdy[0] = 1'b1; rdy[1] = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("p3_count0", 32'(nlog[0] - b0), 32'd12);
        chk("p3_count1", 32'(nlog[1] - b1), 32'd12);
        chk("p3_pops0",  32'(npop[0] - p0), 32'd3);
        chk("p3_pops1",  32'(npop[1] - p1), 32'd3);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("p3_sync%0d", i),  32'(lg_d[0][b0 + i]), 32'(EXP3_LSB[i]));
            chk($sformatf("p3_async%0d", i), 32'(lg_d[1][b1 + i]), 32'(EXP3_MSB[i]));
        end

        // Clear during the second chunk.
        b0 = nlog[0];
        push(0, 32'h44332211); push(0, 32'h88776655);
        wait_valid(0, 20, "clr_wait");
        @(posedge clk);
        #1 clr[0] = 1'b1;
        @(posedge clk);
        #1 clr[0] = 1'b0;
        chk("clr_valid", 32'(v[0]),   32'd0);
        chk("clr_busy",  32'(bsy[0]), 32'd0);
        chk("clr_last",  32'(lst[0]), 32'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("clr_count", 32'(nlog[0] - b0), 32'd5);
        chk("clr_first", 32'(lg_d[0][b0]), 32'h11);
        for (int i = 0; i < 4; i++)
            chk($sformatf("clr_next%0d", i), 32'(lg_d[0][b0 + 1 + i]), 32'(EXP1_LSB[4 + i]));

        // N=1: one chunk every two cycles, each marked last.
        b2 = nlog[2]; p2 = npop[2];
        for (int i = 0; i < 6; i++) push(2, 32'h5A + 32'(i));
        repeat (16) @(posedge clk);
        #1;
        chk("n1_count", 32'(nlog[2] - b2), 32'd6);
        chk("n1_pops",  32'(npop[2] - p2), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("n1_data%0d", i), 32'(lg_d[2][b2 + i]), 32'h5A + 32'(i));
            chk($sformatf("n1_last%0d", i), 32'(lg_l[2][b2 + i]), 32'd1);
            if (i < 5)
                chk($sformatf("n1_gap%0d", i), 32'(lg_c[2][b2 + i + 1] - lg_c[2][b2 + i]), 32'd2);
        end

        // Asynchronous reset while a word is held.
        rdy[2] = 1'b0;
        for (int i = 0; i < 4; i++) push(2, 32'h70 + 32'(i));
        wait_valid(2, 20, "rst_wait");
        #2 rstn = 1'b0;
        #1;
        for (int k = 0; k < ND; k++) begin
            chk($sformatf("arst_valid%0d", k), 32'(v[k]),   32'd0);
            chk($sformatf("arst_data%0d", k),  32'(dat[k]), 32'd0);
            chk($sformatf("arst_last%0d", k),  32'(lst[k]), 32'd0);
            chk($sformatf("arst_busy%0d", k),  32'(bsy[k]), 32'd0);
            chk($sformatf("arst_re%0d", k),    32'(re[k]),  32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        rdy[2] = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
endmodule
